ram_result_writer: RTL

//  Write-back end of the brightness datapath, the inverse of the RAM input loader.

---
 rtl/brightness_pkg.sv | 42 ++++
 rtl/pixel_saturator.sv | 21 ++
 rtl/ram_result_writer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/brightness_pkg.sv
// Shared types, default widths and the pixel clamp for the brightness datapath.
// Latency: none (types, constants and a pure combinational function).
// Backpressure: not applicable.
package brightness_pkg;

  localparam int DEF_RAM_ADDR_W = 6;
  localparam int RAM_DATA_W     = 8;
  localparam int PE_DATA_W      = 16;
  localparam int DEF_DEPTH      = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_VEC = 2'd1,
    WRITE    = 2'd2,
    DONE_ST  = 2'd3
  } writer_state_t;

  typedef struct packed {
    logic                  clamped;
    logic [RAM_DATA_W-1:0] pixel;
  } sat_result_t;

  // Two's complement lane to unsigned pixel: negatives floor at 0, anything
  // with bits set above the pixel width (and sign clear) ceils at all-ones.
  function automatic sat_result_t clamp_pixel(input logic [PE_DATA_W-1:0] x);
    sat_result_t r;
    logic        negative;
    logic        too_big;
    negative  = x[PE_DATA_W-1];
    too_big   = |x[PE_DATA_W-2:RAM_DATA_W];
    r.clamped = negative | too_big;
    if (negative) begin
      r.pixel = '0;
    end else if (too_big) begin
      r.pixel = '1;
    end else begin
      r.pixel = x[RAM_DATA_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pixel_saturator.sv
// Clamps one signed PE result lane to an 8-bit pixel and flags when it clamped.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
module pixel_saturator
  import brightness_pkg::*;
(
  input  logic [PE_DATA_W-1:0]  i_lane,
  output logic [RAM_DATA_W-1:0] o_pixel,
  output logic                  o_clamped
);

  sat_result_t w_res;

  // Pure function of the selected lane.
  always_comb begin
    w_res     = clamp_pixel(i_lane);
    o_pixel   = w_res.pixel;
    o_clamped = w_res.clamped;
  end

endmodule

// File: rtl/ram_result_writer.sv
// Write-back of PE result vectors: clamp each lane, write one pixel per cycle to RAM.
// Latency: vector accepted on cycle N is written on cycles N+1..N+DEPTH.
// Backpressure: data_ready only in WAIT_VEC; at most one vector per DEPTH+1 cycles.
module ram_result_writer
  import brightness_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_W,
  parameter int RAM_DATA_WIDTH = RAM_DATA_W,
  parameter int PE_DATA_WIDTH  = PE_DATA_W,
  parameter int DEPTH          = DEF_DEPTH
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [PE_DATA_WIDTH*DEPTH-1:0]   data_in,
  input  logic                             data_valid,
  output logic                             data_ready,
  output logic [RAM_ADDR_WIDTH-1:0]        ram_address,
  output logic [RAM_DATA_WIDTH-1:0]        ram_wdata,
  output logic                             ram_we,
  output logic [RAM_ADDR_WIDTH:0]          sat_count,
  output logic                             busy,
  output logic                             done
);

  localparam int LW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_BASE = RAM_ADDR_WIDTH'((2**RAM_ADDR_WIDTH) - DEPTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_STEP = RAM_ADDR_WIDTH'(DEPTH);
  localparam logic [LW-1:0]             LAST_LANE = LW'(DEPTH - 1);
  localparam logic [RAM_ADDR_WIDTH:0]   SAT_MAX   = '1;

  writer_state_t                    r_state;
  writer_state_t                    w_next;
  logic [RAM_ADDR_WIDTH-1:0]        r_base_addr;
  logic [LW-1:0]                    r_lane_cnt;
  logic [PE_DATA_WIDTH*DEPTH-1:0]   r_buffer;
  logic [RAM_ADDR_WIDTH:0]          r_sat_count;

  logic [PE_DATA_WIDTH-1:0]         w_lane;
  logic [RAM_DATA_WIDTH-1:0]        w_pixel;
  logic                             w_clamped;
  logic                             w_last_lane;
  logic                             w_last_base;

  assign w_lane      = r_buffer[r_lane_cnt*PE_DATA_WIDTH +: PE_DATA_WIDTH];
  assign w_last_lane = (r_lane_cnt == LAST_LANE);
  assign w_last_base = (r_base_addr == LAST_BASE);
  assign sat_count   = r_sat_count;

  pixel_saturator u_sat (
    .i_lane    (w_lane),
    .o_pixel   (w_pixel),
    .o_clamped (w_clamped)
  );

  // Next-state and state-decoded outputs; RAM port is quiet outside WRITE.
  always_comb begin
    w_next      = r_state;
    data_ready  = 1'b0;
    ram_we      = 1'b0;
    ram_address = '0;
    ram_wdata   = '0;
    busy        = (r_state != IDLE);
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = WAIT_VEC;
      end
      WAIT_VEC: begin
        data_ready = 1'b1;
        if (data_valid) w_next = WRITE;
      end
      WRITE: begin
        ram_we      = 1'b1;
        ram_address = r_base_addr + RAM_ADDR_WIDTH'(r_lane_cnt);
        ram_wdata   = w_pixel;
        if (w_last_lane) w_next = w_last_base ? DONE_ST : WAIT_VEC;
      end
      DONE_ST: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Frame addressing, lane buffer and saturation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_base_addr <= '0;
      r_lane_cnt  <= '0;
      r_buffer    <= '0;
      r_sat_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_base_addr <= '0;
            r_sat_count <= '0;
          end
        end
        WAIT_VEC: begin
          if (data_valid) begin
            r_buffer   <= data_in;
            r_lane_cnt <= '0;
          end
        end
        WRITE: begin
          r_lane_cnt <= r_lane_cnt + 1'b1;
          if (w_clamped && (r_sat_count != SAT_MAX)) r_sat_count <= r_sat_count + 1'b1;
          // Base stays on the last block at frame end so it never wraps.
          if (w_last_lane && !w_last_base) r_base_addr <= r_base_addr + ADDR_STEP;
        end
        default: ;
      endcase
    end
  end

endmodule
